data_io_wide: RTL and testbench
===============================

# data_io_wide

Parametrised successor to the byte-wide ARM→FPGA download port. It runs entirely in `clk_sys`, oversamples the SS2 SPI link, and decodes the file-transfer command set (0x53/0x54/0x55/0x56). It packs download bytes little-endian into `DW`-bit words, buffers them in a `DEPTH`-entry FIFO, and hands them to the core's memory writer over a wr/ack handshake with byte enables. It replaces the `clkref_n` strobe scheme for cores whose SDRAM/BRAM writers run wider than 8 bits or stall unpredictably.

## Interface
- `DW`, 16: output word width; one of 8, 16, 32. `BYTES = DW/8`.
- `AW`, 25: byte-address width.
- `DEPTH`, 8: FIFO depth in words; power of two, ≥2.
- `START_ADDR`, 0: byte address of the first download byte; must be `BYTES`-aligned.
- `clk_sys  in  1`: sole clock; all logic on its rising edge.
- `reset  in  1`: synchronous, active-high.
- `SPI_SCK`, `SPI_SS2`, `SPI_DI`  `in  1`: async SPI from the IO controller, SS2 active-low.
- `ioctl_download  out  1`: transfer active.
- `ioctl_index  out  8`: menu index.
- `ioctl_wr  out  1`: word valid; held until acked.
- `ioctl_ack  in  1`: consumer accepts the current word.
- `ioctl_addr  out  AW`: byte address of `ioctl_dout[7:0]`.
- `ioctl_dout  out  DW`: data word; byte k at bits [8k+7:8k].
- `ioctl_be  out  BYTES`: byte enables.
- `ioctl_overflow  out  1`: sticky; a word was dropped on FIFO full.
- `ioctl_fileext  out  24`, `ioctl_filesize  out  32`: see Configuration.

## Operation
- **SPI front end.**
  - SCK, SS2 and DI each pass through a 2-flop synchroniser. SCK rising edge is detected from flop 2 vs. a third flop.
  - On each rising edge with SS2 low, shift DI in MSB-first.
  - Bit counter counts 0–7 for the command byte, then 8–15 repeating for data bytes.
  - SS2 high clears the bit counter and the byte counter and discards any partial bits. The partial word in the packer is kept.
- **Commands** (on data-byte completion, using the latched command):
  - 0x53, byte bit0=1: clear FIFO and packer; set `addr = START_ADDR`; clear overflow; set `ioctl_download = 1`.
  - 0x53, bit0=0: request end; enter DRAIN.
  - 0x54 while in ACTIVE: byte goes to the packer.
  - 0x55: latch `ioctl_index`.
  - 0x56: file info (see Configuration).
  - Other command codes are ignored.
- **Packer.**
  - Byte slot counter `s` (0..BYTES-1) and `be_acc`.
  - The byte is written to lane `s`, `be_acc[s]` is set, and `s` increments.
  - At `s == BYTES-1` the word {data, be_acc, addr} is pushed to the FIFO, `addr += BYTES`, and the packer clears.
- **FIFO.** Show-ahead. `ioctl_wr` equals not-empty. Pop on `ioctl_wr && ioctl_ack`.
  - Push while full: the word is dropped, `ioctl_overflow` is set, and `addr` still advances.
  - Simultaneous push and pop when full is allowed: no drop.
- **FSM.** States IDLE → ACTIVE → DRAIN → IDLE.
  - IDLE: 0x53/1 goes to ACTIVE.
  - ACTIVE: 0x53/0 goes to DRAIN. 0x53/1 restarts ACTIVE, clearing FIFO and packer.
  - DRAIN:
    - If the packer is non-empty, push the partial word with its `be`. If the FIFO is full, wait a cycle and retry; no drop.
    - Once the FIFO is empty, clear `ioctl_download` and go to IDLE.
    - 0x53/1 received during DRAIN aborts the drain and restarts.
- **Reset values.** All outputs are 0. FSM is in IDLE, FIFO empty, `addr = START_ADDR`.

## Timing
- Requires `clk_sys` ≥ 4× SCK frequency.
- Last SCK rising edge of a byte at the pins to FIFO push (word-completing byte): 4 `clk_sys` cycles (2 sync, 1 edge, 1 pack).
- Push to `ioctl_wr` high: 1 cycle.
- After an ack, the next word is presented the following cycle, so the throughput is 1 word/cycle with ack held high.
- `ioctl_dout`, `ioctl_addr` and `ioctl_be` are stable while `ioctl_wr` is high and not acked.
- `ioctl_download` falls 1 cycle after the FIFO empties in DRAIN.
- `ioctl_index` updates 3 cycles after its last SCK edge.

## Configuration
- `DATA_IO_FILEINFO_EN` defined:
  - 0x56 bytes are counted from 0 per SS2 frame.
  - Bytes 0x08–0x0A go to `ioctl_fileext` [23:16], [15:8], [7:0].
  - Bytes 0x1C–0x1F go to `ioctl_filesize`, little-endian.
  - Both registers reset to 0.
- Not defined:
  - 0x56 is ignored.
  - `ioctl_fileext` and `ioctl_filesize` are tied to 0.
  - No byte counter is synthesised.

## Test plan
- **Basic packing.** DW=16, START_ADDR=0x100. Send 0x53/1, then 0x54 with bytes 11 22 33 44, then 0x53/0, with ack tied high.
  - Expect wr with (0x100, 0x2211, be=11).
  - Expect wr with (0x102, 0x4433, be=11).
  - download falls after the second word.
- **Partial flush.** DW=32. Send bytes AA BB CC, then end.
  - Expect a single wr: addr 0x0, dout[23:0]=0xCCBBAA, be=0111.
  - download stays high until that word is acked.
- **Backpressure and overflow.** DW=8, DEPTH=4, ack held low. Send 6 bytes.
  - Expect 4 words queued and `ioctl_overflow=1`.
  - Release ack: words 0–3 come out at addrs 0–3 in order.
  - A restart with 0x53/1 clears overflow.
- **Index and info.**
  - Send 0x55 with 0x42: `ioctl_index=0x42`.
  - With the macro on, a 32-byte 0x56 frame with "BIN" at 8–10 and 00 10 00 00 at 0x1C: `fileext=0x42494E`, `filesize=0x1000`.
  - With the macro off, both read 0.
- **Abort and reset.**
  - Drop SS2 after 4 bits of a data byte: no push, and the packer slot is unchanged.
  - Assert reset while `ioctl_wr` is high: next cycle all outputs are 0 and the FIFO is empty.

Source files
------------

// File: rtl/data_io_wide_if.sv
// data_io_wide_if: download word handshake (wr/ack) between data_io_wide and the core memory writer.
interface data_io_wide_if #(parameter int DW = 16, parameter int AW = 25);
   logic            ioctl_wr;
   logic            ioctl_ack;
   logic [AW-1:0]   ioctl_addr;
   logic [DW-1:0]   ioctl_dout;
   logic [DW/8-1:0] ioctl_be;
   modport master(output ioctl_wr, ioctl_addr, ioctl_dout, ioctl_be, input ioctl_ack);
   modport slave(input ioctl_wr, ioctl_addr, ioctl_dout, ioctl_be, output ioctl_ack);
endinterface

// File: rtl/data_io_wide.sv
// data_io_wide: oversampled SS2 SPI download port packing bytes into DW-bit words behind a FIFO.
// Optional file-info capture (command 0x56) is built only when DATA_IO_FILEINFO_EN is defined.
module data_io_wide #(
   parameter int            DW         = 16,
   parameter int            AW         = 25,
   parameter int            DEPTH      = 8,
   parameter logic [AW-1:0] START_ADDR = '0
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        SPI_SCK,
   input  logic        SPI_SS2,
   input  logic        SPI_DI,
   output logic        ioctl_download,
   output logic [7:0]  ioctl_index,
   output logic        ioctl_overflow,
   output logic [23:0] ioctl_fileext,
   output logic [31:0] ioctl_filesize,
   data_io_wide_if.master io
);
   localparam int BYTES = DW / 8;
   localparam int SW    = BYTES > 1 ? $clog2(BYTES) : 1;
   localparam int PW    = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
   typedef struct packed {
      logic [AW-1:0]    addr;
      logic [BYTES-1:0] be;
      logic [DW-1:0]    data;
   } word_t;
   logic [2:0]       r_sck;
   logic [1:0]       r_ss, r_di;
   logic [3:0]       r_bit;
   logic [7:0]       r_sr, r_cmd, r_db;
   logic             r_dv;
   state_t           r_state, w_state_n;
   logic [DW-1:0]    r_data, w_pdata;
   logic [BYTES-1:0] r_be, w_pbe;
   logic [SW-1:0]    r_slot;
   logic [AW-1:0]    r_addr;
   word_t            r_mem [DEPTH];
   word_t            w_head;
   logic [PW-1:0]    r_wp, r_rp;
   logic [PW:0]      r_cnt;
   logic w_rise, w_cmd_done, w_data_done, w_start, w_end, w_pbyte;
   logic w_empty, w_full, w_pop, w_flush, w_push, w_wen;
   logic [7:0] w_byte;
   assign w_rise      = r_sck[1] & ~r_sck[2] & ~r_ss[1];
   assign w_byte      = {r_sr[6:0], r_di[1]};
   assign w_cmd_done  = w_rise && r_bit == 4'd7;
   assign w_data_done = w_rise && r_bit == 4'd15;
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_sck       <= '0;
         r_ss        <= '1;
         r_di        <= '0;
         r_bit       <= '0;
         r_sr        <= '0;
         r_cmd       <= '0;
         r_db        <= '0;
         r_dv        <= 1'b0;
         ioctl_index <= '0;
      end else begin
         r_sck <= {r_sck[1:0], SPI_SCK};
         r_ss  <= {r_ss[0], SPI_SS2};
         r_di  <= {r_di[0], SPI_DI};
         r_dv  <= w_data_done;
         if (w_data_done) r_db <= w_byte;
         if (w_cmd_done) r_cmd <= w_byte;
         if (w_data_done && r_cmd == 8'h55) ioctl_index <= w_byte;
         if (r_ss[1]) r_bit <= '0;
         else if (w_rise) begin
            r_sr  <= w_byte;
            r_bit <= r_bit == 4'd15 ? 4'd8 : r_bit + 4'd1;
         end
      end
   end
`ifdef DATA_IO_FILEINFO_EN
   logic [7:0] r_bcnt;
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_bcnt         <= '0;
         ioctl_fileext  <= '0;
         ioctl_filesize <= '0;
      end else begin
         if (r_ss[1]) r_bcnt <= '0;
         else if (w_data_done && r_bcnt != 8'hFF) r_bcnt <= r_bcnt + 8'd1;
         if (w_data_done && r_cmd == 8'h56) begin
            if (r_bcnt == 8'h08) ioctl_fileext[23:16] <= w_byte;
            if (r_bcnt == 8'h09) ioctl_fileext[15:8] <= w_byte;
            if (r_bcnt == 8'h0A) ioctl_fileext[7:0] <= w_byte;
            if (r_bcnt[7:2] == 6'h07) ioctl_filesize[{r_bcnt[1:0], 3'b000} +: 8] <= w_byte;
         end
      end
   end
`else
   assign ioctl_fileext  = '0;
   assign ioctl_filesize = '0;
`endif
   assign w_start = r_dv && r_cmd == 8'h53 && r_db[0];
   assign w_end   = r_dv && r_cmd == 8'h53 && !r_db[0];
   assign w_pbyte = r_dv && r_cmd == 8'h54 && r_state == ACTIVE;
   assign w_empty = r_cnt == '0;
   assign w_full  = r_cnt == (PW+1)'(DEPTH);
   assign w_pop   = !w_empty && io.ioctl_ack;
   // a drain flush never drops: it simply waits for room
   assign w_flush = r_state == DRAIN && |r_be && !w_full;
   assign w_push  = (w_pbyte && r_slot == SW'(BYTES - 1)) || w_flush;
   assign w_wen   = w_push && (!w_full || w_pop);
   always_comb begin
      w_pdata = r_data;
      w_pbe   = r_be;
      if (w_pbyte) begin
         w_pdata[{r_slot, 3'b000} +: 8] = r_db;
         w_pbe[r_slot] = 1'b1;
      end
   end
   always_comb begin
      w_state_n = w_start ? ACTIVE :
                  (r_state == ACTIVE && w_end) ? DRAIN :
                  (r_state == DRAIN && w_empty && !(|r_be)) ? IDLE : r_state;
   end
   always_ff @(posedge clk_sys) begin
      r_state <= reset ? IDLE : w_state_n;
   end
   always_ff @(posedge clk_sys) begin
      if (reset || w_start) begin
         r_data         <= '0;
         r_be           <= '0;
         r_slot         <= '0;
         r_addr         <= START_ADDR;
         r_wp           <= '0;
         r_rp           <= '0;
         r_cnt          <= '0;
         ioctl_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_data <= '0;
            r_be   <= '0;
            r_slot <= '0;
            r_addr <= r_addr + AW'(BYTES);
         end else if (w_pbyte) begin
            r_data <= w_pdata;
            r_be   <= w_pbe;
            r_slot <= r_slot + SW'(1);
         end
         if (w_push && !w_wen) ioctl_overflow <= 1'b1;
         if (w_wen) r_wp <= r_wp + PW'(1);
         if (w_pop) r_rp <= r_rp + PW'(1);
         r_cnt <= r_cnt + (PW+1)'(w_wen) - (PW+1)'(w_pop);
      end
   end
   always_ff @(posedge clk_sys) begin
      if (w_wen) r_mem[r_wp] <= '{addr: r_addr, be: w_pbe, data: w_pdata};
   end
   assign w_head         = r_mem[r_rp];
   assign ioctl_download = r_state != IDLE;
   assign io.ioctl_wr    = !w_empty;
   assign io.ioctl_addr  = w_empty ? '0 : w_head.addr;
   assign io.ioctl_dout  = w_empty ? '0 : w_head.data;
   assign io.ioctl_be    = w_empty ? '0 : w_head.be;
endmodule

// File: tb/tb_data_io_wide.sv
// tb_data_io_wide: scoreboard bench for data_io_wide (DW=16, DEPTH=4, START_ADDR=0x100) over bit-banged SPI.
module tb_data_io_wide;
   logic clk_sys = 1'b0, reset = 1'b1, sck = 1'b0, ss2 = 1'b1, di = 1'b0;
   logic dl, ovf;
   logic [7:0]  idx;
   logic [23:0] fext;
   logic [31:0] fsz;
   data_io_wide_if #(.DW(16), .AW(25)) io();
   data_io_wide #(.DW(16), .AW(25), .DEPTH(4), .START_ADDR(25'h100)) dut (
      .clk_sys(clk_sys), .reset(reset), .SPI_SCK(sck), .SPI_SS2(ss2), .SPI_DI(di),
      .ioctl_download(dl), .ioctl_index(idx), .ioctl_overflow(ovf),
      .ioctl_fileext(fext), .ioctl_filesize(fsz), .io(io)
   );
   always #5 clk_sys = ~clk_sys;
   typedef struct packed {logic [24:0] a; logic [15:0] d; logic [1:0] be;} exp_t;
   exp_t sb[$];
   int n_cmp = 0, n_bad = 0;
   logic [7:0] bytes [64];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask
   task automatic expect_w(input logic [24:0] a, input logic [15:0] d, input logic [1:0] be);
      sb.push_back('{a: a, d: d, be: be});
   endtask
   always @(negedge clk_sys) begin
      if (!reset && io.ioctl_wr && io.ioctl_ack) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected word: addr %0h dout %0h be %0h", io.ioctl_addr, io.ioctl_dout, io.ioctl_be);
         end else begin
            exp_t e;
            logic [15:0] m;
            e = sb.pop_front();
            m = {{8{e.be[1]}}, {8{e.be[0]}}};
            chk("word addr", 32'(io.ioctl_addr), 32'(e.a));
            chk("word be", 32'(io.ioctl_be), 32'(e.be));
            chk("word data", 32'(io.ioctl_dout & m), 32'(e.d & m));
         end
      end
   end
   task automatic send(input logic [7:0] b, input int nb);
      for (int i = 7; i > 7 - nb; i--) begin
         di = b[i];
         #40 sck = 1'b1;
         #40 sck = 1'b0;
      end
   endtask
   task automatic frame(input logic [7:0] cmd, input int n, input int tail);
      ss2 = 1'b0;
      #40;
      send(cmd, 8);
      for (int i = 0; i < n; i++) send(bytes[i], 8);
      if (tail > 0) send(bytes[n], tail);
      #40 ss2 = 1'b1;
      #200;
   endtask
   task automatic start_dl();
      bytes[0] = 8'h01;
      frame(8'h53, 1, 0);
   endtask
   task automatic end_dl(input string nm);
      bytes[0] = 8'h00;
      frame(8'h53, 1, 0);
      for (int i = 0; i < 3000 && dl; i++) @(posedge clk_sys);
      #1 chk(nm, 32'(dl), 0);
   endtask
   task automatic set_ack(input logic v);
      @(posedge clk_sys);
      #1 io.ioctl_ack = v;
   endtask
   task automatic chk_outputs_zero(input string tag);
      chk({tag, " download"}, 32'(dl), 0);
      chk({tag, " wr"}, 32'(io.ioctl_wr), 0);
      chk({tag, " index"}, 32'(idx), 0);
      chk({tag, " overflow"}, 32'(ovf), 0);
      chk({tag, " addr"}, 32'(io.ioctl_addr), 0);
      chk({tag, " dout"}, 32'(io.ioctl_dout), 0);
      chk({tag, " be"}, 32'(io.ioctl_be), 0);
      chk({tag, " fileext"}, 32'(fext), 0);
      chk({tag, " filesize"}, fsz, 0);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   initial begin
      io.ioctl_ack = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1 chk_outputs_zero("reset");
      reset = 1'b0;
      // basic packing, ack held high
      set_ack(1'b1);
      start_dl();
      chk("download rises", 32'(dl), 1);
      bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
      expect_w(25'h100, 16'h2211, 2'b11);
      expect_w(25'h102, 16'h4433, 2'b11);
      frame(8'h54, 4, 0);
      end_dl("basic download falls");
      chk("basic words seen", 32'(sb.size()), 0);
      // partial flush held until ack
      start_dl();
      set_ack(1'b0);
      bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC;
      expect_w(25'h100, 16'hBBAA, 2'b11);
      expect_w(25'h102, 16'h00CC, 2'b01);
      frame(8'h54, 3, 0);
      bytes[0] = 8'h00;
      frame(8'h53, 1, 0);
      repeat (20) @(posedge clk_sys);
      #1 chk("partial download held", 32'(dl), 1);
      chk("partial wr held", 32'(io.ioctl_wr), 1);
      chk("partial head addr stable", 32'(io.ioctl_addr), 32'h100);
      set_ack(1'b1);
      for (int i = 0; i < 3000 && dl; i++) @(posedge clk_sys);
      #1 chk("partial download falls", 32'(dl), 0);
      chk("partial words seen", 32'(sb.size()), 0);
      // backpressure and overflow
      set_ack(1'b0);
      start_dl();
      for (int i = 0; i < 12; i++) bytes[i] = 8'h10 + 8'(i);
      expect_w(25'h100, 16'h1110, 2'b11);
      expect_w(25'h102, 16'h1312, 2'b11);
      expect_w(25'h104, 16'h1514, 2'b11);
      expect_w(25'h106, 16'h1716, 2'b11);
      frame(8'h54, 12, 0);
      chk("overflow set", 32'(ovf), 1);
      chk("backpressure wr", 32'(io.ioctl_wr), 1);
      set_ack(1'b1);
      for (int i = 0; i < 3000 && io.ioctl_wr; i++) @(posedge clk_sys);
      #1 chk("backpressure fifo drains", 32'(io.ioctl_wr), 0);
      chk("backpressure words seen", 32'(sb.size()), 0);
      start_dl();
      chk("restart clears overflow", 32'(ovf), 0);
      end_dl("backpressure download falls");
      // index and file info
      bytes[0] = 8'h42;
      frame(8'h55, 1, 0);
      chk("index latched", 32'(idx), 32'h42);
      for (int i = 0; i < 32; i++) bytes[i] = 8'h00;
      bytes[8] = 8'h42; bytes[9] = 8'h49; bytes[10] = 8'h4E; bytes[29] = 8'h10;
      frame(8'h56, 32, 0);
`ifdef DATA_IO_FILEINFO_EN
      chk("fileext", 32'(fext), 32'h42494E);
      chk("filesize", fsz, 32'h1000);
`else
      chk("fileext off", 32'(fext), 0);
      chk("filesize off", fsz, 0);
`endif
      // SS2 abort mid-byte keeps packer slot
      start_dl();
      bytes[0] = 8'h5A;
      frame(8'h54, 1, 0);
      bytes[0] = 8'hFF;
      frame(8'h54, 0, 4);
      chk("abort no push", 32'(io.ioctl_wr), 0);
      expect_w(25'h100, 16'h6B5A, 2'b11);
      bytes[0] = 8'h6B;
      frame(8'h54, 1, 0);
      chk("abort word seen", 32'(sb.size()), 0);
      // reset while a word is pending
      set_ack(1'b0);
      bytes[0] = 8'h11; bytes[1] = 8'h22;
      frame(8'h54, 2, 0);
      chk("pending before reset", 32'(io.ioctl_wr), 1);
      @(posedge clk_sys);
      #1 reset = 1'b1;
      @(posedge clk_sys);
      #1 chk_outputs_zero("mid reset");
      reset = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1 chk("fifo empty after reset", 32'(io.ioctl_wr), 0);
      chk("scoreboard empty", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
